// File: rtl/fetch_unit_pkg.sv
// Shared pipeline-register types plus the fetch-stage state encoding and reset PC.
package fetch_unit_pkg;

    typedef struct packed {
        logic [8:0]  Curr_Pc;
        logic [31:0] Curr_Instr;
    } if_id_reg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        DISCARD
    } fetch_state_t;

    localparam logic [8:0] FETCH_RESET_PC = 9'h000;

    function automatic logic [8:0] next_pc(input logic [8:0] pc);
        return pc + 9'd4;
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding imem request, IF/ID register,
// stall/flush handling and redirect with discard of in-flight responses.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [8:0] RESET_PC = FETCH_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [8:0]  redirect_pc,
    output logic        imem_req,
    output logic [8:0]  imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output if_id_reg    if_id,
    output logic        if_id_valid
);

    fetch_state_t state;
    logic [8:0]   pc;
    logic [8:0]   drop_addr;
    if_id_reg     pending;

    // While discarding, the abandoned request's address stays on the bus until its ack.
    assign imem_req  = (state == REQ) || (state == DISCARD);
    assign imem_addr = (state == DISCARD) ? drop_addr : pc;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            drop_addr   <= '0;
            pending     <= '0;
            if_id       <= '0;
            if_id_valid <= 1'b0;
        end else begin
            if (!stall) begin
                if_id_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    state <= REQ;
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                    end
                end

                REQ: begin
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                        if (!imem_ack) begin
                            state     <= DISCARD;
                            drop_addr <= pc;
                        end
                    end else if (imem_ack) begin
                        if (stall) begin
                            pending <= '{Curr_Pc: pc, Curr_Instr: imem_rdata};
                            state   <= HOLD;
                        end else begin
                            if_id       <= '{Curr_Pc: pc, Curr_Instr: imem_rdata};
                            if_id_valid <= 1'b1;
                            pc          <= next_pc(pc);
                        end
                    end
                end

                HOLD: begin
                    if (redirect_valid) begin
                        pc      <= redirect_pc;
                        pending <= '0;
                        state   <= REQ;
                    end else if (!stall) begin
                        if_id       <= pending;
                        if_id_valid <= 1'b1;
                        pc          <= next_pc(pc);
                        state       <= REQ;
                    end
                end

                DISCARD: begin
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                    end
                    if (imem_ack) begin
                        state <= REQ;
                    end
                end

                default: state <= IDLE;
            endcase

            // Flush overrides any hold or load scheduled above.
            if (flush) begin
                if_id       <= '0;
                if_id_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a transaction-level reference model checked every cycle.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [8:0]  RST_PC = 9'h000;
    localparam logic [31:0] I1 = 32'h00500093;
    localparam logic [31:0] I2 = 32'h00100113;
    localparam logic [31:0] I3 = 32'h002081B3;
    localparam logic [31:0] I4 = 32'h00310233;
    localparam logic [31:0] I5 = 32'h0000006F;
    localparam logic [31:0] I6 = 32'h40208033;
    localparam logic [31:0] I7 = 32'h00A00513;
    localparam logic [31:0] JUNK = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [8:0]  redirect_pc;
    logic        imem_req;
    logic [8:0]  imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    if_id_reg    if_id;
    logic        if_id_valid;

    int checks = 0;
    int errors = 0;

    // Reference model: fetch address, "started" flag, parked response, dropping-in-flight flag.
    logic [8:0] m_pc = RST_PC;
    logic [8:0] m_drop_addr = '0;
    bit         m_started = 0;
    bit         m_parked = 0;
    bit         m_dropping = 0;
    if_id_reg   m_park = '0;
    if_id_reg   m_if = '0;
    bit         m_v = 0;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .if_id          (if_id),
        .if_id_valid    (if_id_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic model_edge();
        bit       fetching;
        bit       loaded;
        if_id_reg ld;
        loaded = 0;
        ld     = '0;
        if (!reset) begin
            m_pc        = RST_PC;
            m_drop_addr = '0;
            m_started   = 0;
            m_parked    = 0;
            m_dropping  = 0;
            m_park      = '0;
            m_if        = '0;
            m_v         = 0;
            return;
        end
        fetching = m_started && !m_parked;
        if (redirect_valid) begin
            if (fetching && !m_dropping && !imem_ack) begin
                m_dropping  = 1;
                m_drop_addr = m_pc;
            end else if (m_dropping && imem_ack) begin
                m_dropping = 0;
            end
            m_parked  = 0;
            m_started = 1;
            m_pc      = redirect_pc;
        end else if (!m_started) begin
            m_started = 1;
        end else if (m_parked) begin
            if (!stall) begin
                loaded   = 1;
                ld       = m_park;
                m_parked = 0;
                m_pc     = m_pc + 9'd4;
            end
        end else if (m_dropping) begin
            if (imem_ack) m_dropping = 0;
        end else if (imem_ack) begin
            if (stall) begin
                m_park   = '{Curr_Pc: m_pc, Curr_Instr: imem_rdata};
                m_parked = 1;
            end else begin
                loaded = 1;
                ld     = '{Curr_Pc: m_pc, Curr_Instr: imem_rdata};
                m_pc   = m_pc + 9'd4;
            end
        end
        if (flush) begin
            m_if = '0;
            m_v  = 0;
        end else if (loaded) begin
            m_if = ld;
            m_v  = 1;
        end else if (!stall) begin
            m_v = 0;
        end
    endtask

    task automatic compare_all();
        chk("imem_req", 64'(imem_req), 64'(m_started && !m_parked));
        chk("imem_addr", 64'(imem_addr), 64'(m_dropping ? m_drop_addr : m_pc));
        chk("if_id_valid", 64'(if_id_valid), 64'(m_v));
        if (m_v || !reset) chk("if_id", 64'(if_id), 64'(m_if));
    endtask

    task automatic step(input logic s, input logic f, input logic rv, input logic [8:0] rpc,
                        input logic ack, input logic [31:0] rd);
        stall          = s;
        flush          = f;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_ack       = ack;
        imem_rdata     = rd;
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic lit_out(input string name, input logic req, input logic [8:0] addr,
                           input logic v, input logic [8:0] ipc, input logic [31:0] ins);
        chk({name, ".req"}, 64'(imem_req), 64'(req));
        if (req) chk({name, ".addr"}, 64'(imem_addr), 64'(addr));
        chk({name, ".valid"}, 64'(if_id_valid), 64'(v));
        chk({name, ".if_id"}, 64'(if_id), 64'({ipc, ins}));
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0;
        redirect_pc = '0; imem_ack = 1'b0; imem_rdata = '0;

        step(0, 0, 0, 9'h000, 0, 32'h0);
        step(0, 0, 0, 9'h000, 1, JUNK);
        lit_out("reset", 0, 9'h000, 0, 9'h000, 32'h0);

        reset = 1'b1;
        step(0, 0, 0, 9'h000, 0, 32'h0);
        lit_out("idle_to_req", 1, 9'h000, 0, 9'h000, 32'h0);
        step(0, 0, 0, 9'h000, 1, I1);
        lit_out("first_fetch", 1, 9'h004, 1, 9'h000, I1);
        step(0, 0, 0, 9'h000, 1, I2);
        lit_out("second_fetch", 1, 9'h008, 1, 9'h004, I2);

        step(1, 0, 0, 9'h000, 1, I3);
        lit_out("stall_ack", 0, 9'h008, 1, 9'h004, I2);
        step(1, 0, 0, 9'h000, 0, 32'h0);
        step(1, 0, 0, 9'h000, 0, 32'h0);
        lit_out("stall_held", 0, 9'h008, 1, 9'h004, I2);
        step(0, 0, 0, 9'h000, 0, 32'h0);
        lit_out("stall_release", 1, 9'h00C, 1, 9'h008, I3);

        step(0, 0, 0, 9'h000, 1, I4);
        lit_out("fetch_c", 1, 9'h010, 1, 9'h00C, I4);
        step(0, 0, 0, 9'h000, 0, 32'h0);
        step(0, 0, 1, 9'h040, 0, 32'h0);
        chk("discard.addr_held", 64'(imem_addr), 64'(9'h010));
        step(0, 0, 0, 9'h000, 0, 32'h0);
        step(0, 0, 0, 9'h000, 1, JUNK);
        chk("discard.valid", 64'(if_id_valid), 64'(1'b0));
        chk("discard.addr_new", 64'(imem_addr), 64'(9'h040));
        step(0, 0, 0, 9'h000, 1, I5);
        lit_out("after_redirect", 1, 9'h044, 1, 9'h040, I5);

        step(1, 1, 0, 9'h000, 0, 32'h0);
        lit_out("flush_over_stall", 1, 9'h044, 0, 9'h000, 32'h0);

        step(0, 0, 1, 9'h1FC, 1, JUNK);
        chk("redir_ack.addr", 64'(imem_addr), 64'(9'h1FC));
        chk("redir_ack.valid", 64'(if_id_valid), 64'(1'b0));
        step(0, 0, 0, 9'h000, 1, I6);
        lit_out("wrap", 1, 9'h000, 1, 9'h1FC, I6);

        step(1, 0, 0, 9'h000, 1, I7);
        step(1, 0, 1, 9'h080, 0, 32'h0);
        lit_out("redirect_hold", 1, 9'h080, 1, 9'h1FC, I6);
        step(0, 0, 0, 9'h000, 1, I7);
        lit_out("fetch_80", 1, 9'h084, 1, 9'h080, I7);

        step(0, 0, 0, 9'h000, 0, 32'h0);
        reset = 1'b0;
        step(1, 1, 1, 9'h0F0, 1, JUNK);
        lit_out("reset_mid_req", 0, 9'h000, 0, 9'h000, 32'h0);
        step(0, 0, 0, 9'h000, 0, 32'h0);
        reset = 1'b1;
        step(0, 0, 0, 9'h000, 1, JUNK);
        lit_out("ack_in_idle", 1, RST_PC, 0, 9'h000, 32'h0);
        step(0, 0, 0, 9'h000, 1, I1);
        lit_out("post_reset_fetch", 1, 9'h004, 1, RST_PC, I1);

        step(0, 0, 1, 9'h020, 0, 32'h0);
        step(0, 0, 1, 9'h030, 0, 32'h0);
        chk("double_redirect.addr_held", 64'(imem_addr), 64'(9'h004));
        step(0, 0, 0, 9'h000, 1, JUNK);
        chk("double_redirect.addr", 64'(imem_addr), 64'(9'h030));
        step(0, 0, 0, 9'h000, 1, I2);
        lit_out("double_redirect.fetch", 1, 9'h034, 1, 9'h030, I2);

        reset = 1'b0;
        step(0, 0, 0, 9'h000, 0, 32'h0);
        reset = 1'b1;
        step(0, 0, 1, 9'h100, 0, 32'h0);
        lit_out("redirect_idle", 1, 9'h100, 0, 9'h000, 32'h0);
        step(0, 0, 0, 9'h000, 1, I3);
        lit_out("fetch_100", 1, 9'h104, 1, 9'h100, I3);
        step(0, 0, 0, 9'h000, 0, 32'h0);
        step(0, 0, 0, 9'h000, 0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
